cordic_iter_ctrl: RTL

//  Sequencer for the iterative CORDIC core. Accepts an operation via valid/ready,

---
 rtl/cordic_ctrl_pkg.sv | 20 ++
 rtl/cordic_iter_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: state and mode
// encodings plus default counter geometry.
package cordic_ctrl_pkg;

  localparam int DEF_ITER_W = 5;
  localparam int DEF_N_ITER = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

endpackage

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: accepts an op, steps a sibling down-counter through
// N_ITER micro-rotations and presents the result. Macro CORDIC_SCALE_STEP_EN adds SCALE.
module cordic_iter_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int ITER_W = DEF_ITER_W,
  parameter int N_ITER = DEF_N_ITER
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              soft_clr,
  input  logic              op_valid,
  input  logic              op_mode,
  output logic              op_ready,
  output logic              res_valid,
  input  logic              res_ready,
  input  logic [ITER_W-1:0] cnt_q,
  input  logic              cnt_min_tick,
  output logic              cnt_load,
  output logic [ITER_W-1:0] cnt_d,
  output logic              cnt_en,
  output logic              cnt_up,
  output logic              cnt_syn_clr,
  output logic              load_op,
  output logic              iter_en,
  output logic [ITER_W-1:0] iter_idx,
  output logic              mode_q,
  output logic              scale_en,
  output logic              load_res,
  output ctrl_state_e       dbg_state
);

  localparam logic [ITER_W-1:0] LAST_CNT = ITER_W'(N_ITER - 1);

  ctrl_state_e state_q, state_d;
  logic        mode_d;

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
  // valid never depends on ready, and ready here depends only on state and soft_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    op_ready    = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    cnt_syn_clr = 1'b0;
    load_op     = 1'b0;
    iter_en     = 1'b0;
    scale_en    = 1'b0;
    load_res    = 1'b0;
    if (soft_clr) begin
      state_d     = ST_IDLE;
      cnt_syn_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          op_ready = 1'b1;
          if (op_valid) begin
            cnt_load = 1'b1;
            load_op  = 1'b1;
            mode_d   = op_mode;
            state_d  = ST_ITER;
          end
        end
        ST_ITER: begin
          iter_en = 1'b1;
          // Counter is held at zero on the last iteration so it never wraps.
          if (!cnt_min_tick) begin
            cnt_en = 1'b1;
          end else begin
`ifdef CORDIC_SCALE_STEP_EN
            state_d = ST_SCALE;
`else
            load_res = 1'b1;
            state_d  = ST_DONE;
`endif
          end
        end
        ST_SCALE: begin
`ifdef CORDIC_SCALE_STEP_EN
          scale_en = 1'b1;
          load_res = 1'b1;
          state_d  = ST_DONE;
`else
          state_d  = ST_IDLE;
`endif
        end
        ST_DONE: begin
          if (res_ready) begin
            cnt_syn_clr = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign res_valid = (state_q == ST_DONE);
  assign cnt_d     = LAST_CNT;
  assign cnt_up    = 1'b0;
  assign iter_idx  = LAST_CNT - cnt_q;
  assign dbg_state = state_q;

endmodule
